// File: rtl/memory_responder.sv
// memory_responder: memory end of the worker handshake, word RAM plus in-order response FIFO
// Ports:
//   CLK, RST                  clock, synchronous active-high reset
//   REQ_ADDR_VALID, REQ_ADDR  request strobe and word address
//   REQ_DATA_VALID, REQ_DATA  write qualifier and write data
//   REQ_READY                 request accepted on REQ_ADDR_VALID && REQ_READY
//   RESP_VALID, RESP_DATA     response word (read data or write echo)
//   RESP_READY                response consumed on RESP_VALID && RESP_READY
// Build option MEMORY_RESPONDER_BOUNDS_CHECK_EN: addresses with bits above ADDR_WIDTH set
//   answer 32'hDEAD_BEEF and never write the RAM; otherwise the address wraps.
module memory_responder #(
    parameter int ADDR_WIDTH      = 10,
    parameter int READ_LATENCY    = 2,
    parameter int RESP_FIFO_DEPTH = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        REQ_ADDR_VALID,
    input  logic [31:0] REQ_ADDR,
    input  logic        REQ_DATA_VALID,
    input  logic [31:0] REQ_DATA,
    output logic        REQ_READY,
    output logic        RESP_VALID,
    output logic [31:0] RESP_DATA,
    input  logic        RESP_READY
);
    localparam int PW = $clog2(RESP_FIFO_DEPTH) + 1;
    localparam int NS = READ_LATENCY - 1;

    logic [31:0]           ram [2**ADDR_WIDTH];
    logic [31:0]           fifo_q [RESP_FIFO_DEPTH];
    logic [31:0]           fifo_d [RESP_FIFO_DEPTH];
    logic [PW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d, inflight_q, inflight_d;
    logic                  acc, pop, oob, in_v;
    logic [31:0]           res, in_d;
    logic [ADDR_WIDTH-1:0] idx;

`ifdef MEMORY_RESPONDER_BOUNDS_CHECK_EN
    assign oob = |REQ_ADDR[31:ADDR_WIDTH];
`else
    logic unused_hi;
    assign oob       = 1'b0;
    assign unused_hi = ^REQ_ADDR[31:ADDR_WIDTH];
`endif

    assign idx        = REQ_ADDR[ADDR_WIDTH-1:0];
    // inflight covers pipe stages and FIFO entries, so a credit here guarantees a FIFO slot
    assign REQ_READY  = !RST && (inflight_q < PW'(RESP_FIFO_DEPTH));
    assign acc        = REQ_ADDR_VALID && REQ_READY;
    assign RESP_VALID = wptr_q != rptr_q;
    assign pop        = RESP_VALID && RESP_READY;
    assign RESP_DATA  = RESP_VALID ? fifo_q[rptr_q[PW-2:0]] : 32'd0;
    assign res        = oob ? 32'hDEAD_BEEF : REQ_DATA_VALID ? REQ_DATA : ram[idx];

    always_ff @(posedge CLK) begin
        if (acc && REQ_DATA_VALID && !oob) ram[idx] <= REQ_DATA;
    end

    generate
        if (NS == 0) begin : g_direct
            assign in_v = acc;
            assign in_d = res;
        end else begin : g_pipe
            logic [NS-1:0] pv_q, pv_d;
            logic [31:0]   pd_q [NS];
            logic [31:0]   pd_d [NS];
            always_comb begin
                pv_d[0] = acc;
                pd_d[0] = res;
                for (int i = 1; i < NS; i++) begin
                    pv_d[i] = pv_q[i-1];
                    pd_d[i] = pd_q[i-1];
                end
                if (RST) pv_d = '0;
            end
            always_ff @(posedge CLK) begin
                pv_q <= pv_d;
                pd_q <= pd_d;
            end
            assign in_v = pv_q[NS-1];
            assign in_d = pd_q[NS-1];
        end
    endgenerate

    always_comb begin
        fifo_d = fifo_q;
        if (in_v) fifo_d[wptr_q[PW-2:0]] = in_d;
        wptr_d     = RST ? '0 : wptr_q + PW'(in_v);
        rptr_d     = RST ? '0 : rptr_q + PW'(pop);
        inflight_d = RST ? '0 : inflight_q + PW'(acc) - PW'(pop);
    end

    always_ff @(posedge CLK) begin
        fifo_q     <= fifo_d;
        wptr_q     <= wptr_d;
        rptr_q     <= rptr_d;
        inflight_q <= inflight_d;
    end
endmodule

// File: tb/tb_memory_responder.sv
// tb_memory_responder: self-checking bench for memory_responder
module tb_memory_responder;
    localparam int AW = 10;
    localparam int RL = 2;
    localparam int D  = 4;

    typedef struct {
        logic [31:0] d;
        int          t;
    } exp_t;

    typedef struct {
        logic        we;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] e;
    } vec_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        REQ_ADDR_VALID = 1'b0;
    logic [31:0] REQ_ADDR = '0;
    logic        REQ_DATA_VALID = 1'b0;
    logic [31:0] REQ_DATA = '0;
    logic        REQ_READY;
    logic        RESP_VALID;
    logic [31:0] RESP_DATA;
    logic        RESP_READY = 1'b0;

    int          cyc = 0;
    int          pops = 0;
    int          n_pass = 0;
    int          n_tot = 0;
    exp_t        q[$];
    logic [31:0] mm [2**AW];
    vec_t        tbl[8];

    memory_responder #(.ADDR_WIDTH(AW), .READ_LATENCY(RL), .RESP_FIFO_DEPTH(D)) dut (
        .CLK(CLK), .RST(RST),
        .REQ_ADDR_VALID(REQ_ADDR_VALID), .REQ_ADDR(REQ_ADDR),
        .REQ_DATA_VALID(REQ_DATA_VALID), .REQ_DATA(REQ_DATA),
        .REQ_READY(REQ_READY),
        .RESP_VALID(RESP_VALID), .RESP_DATA(RESP_DATA), .RESP_READY(RESP_READY)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    endfunction

    function automatic logic [31:0] model(input logic we, input logic [31:0] a, input logic [31:0] d);
        logic [AW-1:0] i;
        i = a[AW-1:0];
`ifdef MEMORY_RESPONDER_BOUNDS_CHECK_EN
        if ((a >> AW) != 0) return 32'hDEAD_BEEF;
`endif
        if (we) mm[i] = d;
        return mm[i];
    endfunction

    // Scoreboard: every accepted request is owed one response, in order, visible exactly RL-1
    // cycles after the accepting edge when the FIFO is otherwise drained.
    always @(negedge CLK) begin
        if (cyc > 0) begin
            chk("req_ready", 32'(REQ_READY), 32'(!RST && q.size() < D));
            chk("resp_valid", 32'(RESP_VALID), 32'(q.size() > 0 && q[0].t <= cyc));
            if (RESP_VALID && RESP_READY && q.size() > 0) begin
                chk("resp_data", RESP_DATA, q[0].d);
                void'(q.pop_front());
                pops++;
            end
            if (REQ_ADDR_VALID && REQ_READY)
                q.push_back('{model(REQ_DATA_VALID, REQ_ADDR, REQ_DATA), cyc + RL});
            if (RST) q.delete();
        end
    end

    task automatic send(input logic we, input logic [31:0] a, input logic [31:0] d, input bit rnd);
        int n;
        n = 0;
        REQ_ADDR_VALID = 1'b1;
        REQ_DATA_VALID = we;
        REQ_ADDR = a;
        REQ_DATA = d;
        if (rnd) RESP_READY = $urandom_range(0, 3) != 0;
        @(negedge CLK);
        while (!REQ_READY && n < 50) begin
            @(posedge CLK);
            #1;
            if (rnd) RESP_READY = $urandom_range(0, 3) != 0;
            @(negedge CLK);
            n++;
        end
        if (!REQ_READY) chk("send_timeout", 32'(REQ_READY), 32'd1);
        @(posedge CLK);
        #1;
        REQ_ADDR_VALID = 1'b0;
        REQ_DATA_VALID = 1'b0;
    endtask

    task automatic wait_resp(input string nm);
        int n;
        n = 0;
        @(negedge CLK);
        while (!RESP_VALID && n < 20) begin
            @(negedge CLK);
            n++;
        end
        if (!RESP_VALID) chk({nm, "_timeout"}, 32'(RESP_VALID), 32'd1);
    endtask

    task automatic xact(input logic we, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] e, input string nm);
        int ta;
        RESP_READY = 1'b1;
        send(we, a, d, 1'b0);
        ta = cyc;
        wait_resp(nm);
        chk({nm, "_lat"}, 32'(cyc - ta), 32'(RL - 1));
        chk(nm, RESP_DATA, e);
        @(posedge CLK);
        #1;
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        RESP_READY = 1'b1;
        while (q.size() > 0 && n < 50) begin
            @(posedge CLK);
            #1;
            n++;
        end
        chk(nm, 32'(q.size()), 32'd0);
    endtask

    initial begin
        int k, c0, p0;
        logic [31:0] a;
`ifdef MEMORY_RESPONDER_BOUNDS_CHECK_EN
        tbl[0] = '{1'b1, 32'd5,          32'h1234_5678, 32'h1234_5678};
        tbl[1] = '{1'b0, 32'd5,          32'h0,         32'h1234_5678};
        tbl[2] = '{1'b1, 32'd3,          32'hA5A5_0001, 32'hA5A5_0001};
        tbl[3] = '{1'b0, 32'd1027,       32'h0,         32'hDEAD_BEEF};
        tbl[4] = '{1'b1, 32'd1027,       32'h0BAD_F00D, 32'hDEAD_BEEF};
        tbl[5] = '{1'b0, 32'd3,          32'h0,         32'hA5A5_0001};
        tbl[6] = '{1'b1, 32'h3FF,        32'hCAFE_0001, 32'hCAFE_0001};
        tbl[7] = '{1'b0, 32'hFFFF_FFFF,  32'h0,         32'hDEAD_BEEF};
`else
        tbl[0] = '{1'b1, 32'd5,          32'h1234_5678, 32'h1234_5678};
        tbl[1] = '{1'b0, 32'd5,          32'h0,         32'h1234_5678};
        tbl[2] = '{1'b1, 32'd3,          32'hA5A5_0001, 32'hA5A5_0001};
        tbl[3] = '{1'b0, 32'd1027,       32'h0,         32'hA5A5_0001};
        tbl[4] = '{1'b1, 32'd1027,       32'h0BAD_F00D, 32'h0BAD_F00D};
        tbl[5] = '{1'b0, 32'd3,          32'h0,         32'h0BAD_F00D};
        tbl[6] = '{1'b1, 32'h3FF,        32'hCAFE_0001, 32'hCAFE_0001};
        tbl[7] = '{1'b0, 32'hFFFF_FFFF,  32'h0,         32'hCAFE_0001};
`endif

        // reset held three cycles
        @(negedge CLK);
        chk("rst_ready", 32'(REQ_READY), 32'd0);
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        chk("post_rst_ready", 32'(REQ_READY), 32'd1);
        chk("post_rst_valid", 32'(RESP_VALID), 32'd0);
        chk("post_rst_data", RESP_DATA, 32'd0);
        @(posedge CLK);
        #1;

        // preload low addresses so random reads have known contents
        RESP_READY = 1'b1;
        for (int i = 0; i < 32; i++) send(1'b1, 32'(i), 32'h1000_0000 + 32'(i), 1'b0);
        drain("preload_drain");

        // directed vectors, one isolated transaction each
        for (int i = 0; i < 8; i++)
            xact(tbl[i].we, tbl[i].a, tbl[i].d, tbl[i].e, $sformatf("vec%0d", i));

        // write then read the same word back to back
        send(1'b1, 32'd5, 32'h1234_5678, 1'b0);
        send(1'b0, 32'd5, 32'h0, 1'b0);
        for (int j = 0; j < 2; j++) begin
            wait_resp($sformatf("b2b%0d", j));
            chk($sformatf("b2b%0d", j), RESP_DATA, 32'h1234_5678);
        end
        @(posedge CLK);
        #1;
        drain("b2b_drain");

        // credit limit with responses blocked
        RESP_READY = 1'b0;
        k = 0;
        for (int i = 0; i < 8; i++) begin
            REQ_ADDR_VALID = k < 6;
            REQ_DATA_VALID = 1'b0;
            REQ_ADDR = 32'(10 + k);
            @(negedge CLK);
            if (REQ_ADDR_VALID && REQ_READY) k++;
            @(posedge CLK);
            #1;
        end
        chk("credit_accepted", 32'(k), 32'd4);
        @(negedge CLK);
        chk("credit_full_ready", 32'(REQ_READY), 32'd0);
        @(posedge CLK);
        #1;
        RESP_READY = 1'b1;
        for (int i = 0; i < 12 && k < 6; i++) begin
            REQ_ADDR_VALID = 1'b1;
            REQ_ADDR = 32'(10 + k);
            @(negedge CLK);
            if (REQ_READY) k++;
            @(posedge CLK);
            #1;
        end
        REQ_ADDR_VALID = 1'b0;
        chk("credit_all_accepted", 32'(k), 32'd6);
        drain("credit_drain");

        // reset in the middle of two outstanding reads
        xact(1'b1, 32'd7, 32'h7777_0007, 32'h7777_0007, "rst_wr7");
        send(1'b0, 32'd7, 32'h0, 1'b0);
        send(1'b0, 32'd8, 32'h0, 1'b0);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        repeat (5) begin
            @(negedge CLK);
            chk("rst_mid_no_resp", 32'(RESP_VALID), 32'd0);
            chk("rst_mid_ready", 32'(REQ_READY), 32'd1);
        end
        @(posedge CLK);
        #1;
        xact(1'b0, 32'd7, 32'h0, 32'h7777_0007, "rst_rd7");

        // full throughput: 16 back-to-back requests, 16 responses with no bubbles
        RESP_READY = 1'b1;
        c0 = cyc;
        p0 = pops;
        for (int i = 0; i < 16; i++) send(i[0], 32'(20 + i / 2), 32'hB000_0000 + 32'(i), 1'b0);
        chk("tput_accept_cycles", 32'(cyc - c0), 32'd16);
        repeat (RL) @(posedge CLK);
        #1;
        chk("tput_responses", 32'(pops - p0), 32'd16);

        // randomized traffic with random back-pressure
        for (int i = 0; i < 300; i++) begin
            a = 32'($urandom_range(0, 31));
            if ($urandom_range(0, 7) == 0) a = a | ($urandom << AW);
            send(1'($urandom_range(0, 1)), a, $urandom, 1'b1);
            repeat ($urandom_range(0, 2)) begin
                RESP_READY = $urandom_range(0, 3) != 0;
                @(posedge CLK);
                #1;
            end
        end
        drain("rand_drain");

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
